// File: rtl/rd_busy_scoreboard.sv
// Register busy scoreboard for long-latency writes: flags RAW, WAW and
// structural hazards at decode and tracks how many multicycle writes are in flight.
module rd_busy_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int FP_type     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 id_valid,
    input  logic [4:0]                           id_rs1,
    input  logic [4:0]                           id_rs2,
    input  logic [4:0]                           id_rs3,
    input  logic [2:0]                           id_rs_used,
    input  logic [4:0]                           id_rd,
    input  logic                                 id_wen,
    input  logic                                 id_multicycle,
    input  logic                                 flush,
    input  logic                                 cmp_valid,
    input  logic [4:0]                           cmp_rd,
    output logic                                 no_dependency,
    output logic                                 no_collision,
    output logic                                 rd_not_busy,
    output logic [31:0]                          busy_vec,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_count
);

    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] cmp_mask;
    logic [31:0] set_mask;
    logic [2:0]  raw;
    logic        waw;
    logic        at_limit;
    logic        struct_hz;
    logic        accept;
    logic        mc_issue;
    logic        cnt_inc;
    logic        cnt_dec;

    always_comb begin
        // A register being written back this cycle is treated as already free.
        cmp_mask = cmp_valid ? (32'd1 << cmp_rd) : 32'd0;

        raw[0] = id_rs_used[0] & busy_q[id_rs1] & ~cmp_mask[id_rs1];
        raw[1] = id_rs_used[1] & busy_q[id_rs2] & ~cmp_mask[id_rs2];
        raw[2] = id_rs_used[2] & busy_q[id_rs3] & ~cmp_mask[id_rs3];
        waw    = id_valid & id_wen & busy_q[id_rd] & ~cmp_mask[id_rd];

        at_limit  = (cnt_q == CW'(MAX_PENDING));
        struct_hz = id_valid & id_multicycle & at_limit & ~cmp_valid;

        no_dependency = ~(id_valid & (|raw));
        no_collision  = ~(waw | struct_hz);
        rd_not_busy   = ~busy_q[id_rd];

        accept   = id_valid & no_dependency & no_collision & ~flush;
        mc_issue = accept & id_wen & id_multicycle;

        set_mask = 32'd0;
        if (mc_issue && ((FP_type != 0) || (id_rd != 5'd0))) begin
            set_mask = 32'd1 << id_rd;
        end

        // Clear first, then set, so a same-edge set on the completing register wins.
        busy_d = (busy_q & ~cmp_mask) | set_mask;
        if (FP_type == 0) begin
            busy_d[0] = 1'b0;
        end

        // A completion with nothing in flight is stale and leaves the count alone.
        cnt_dec = cmp_valid & (cnt_q != '0);
        cnt_inc = mc_issue;
        cnt_d   = cnt_q;
        if (cnt_inc && !cnt_dec && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 32'd0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec      = busy_q;
    assign pending_count = cnt_q;

endmodule

// File: tb/tb_rd_busy_scoreboard.sv
// Bench for rd_busy_scoreboard: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a behavioural model.
module tb_rd_busy_scoreboard;

    localparam int MAXP    = 4;
    localparam int FP_TYPE = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rs3;
    logic [2:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_multicycle;
    logic        flush;
    logic        cmp_valid;
    logic [4:0]  cmp_rd;
    logic        no_dependency;
    logic        no_collision;
    logic        rd_not_busy;
    logic [31:0] busy_vec;
    logic [2:0]  pending_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit m_busy [32];
    int m_cnt = 0;

    rd_busy_scoreboard #(.MAX_PENDING(MAXP), .FP_type(FP_TYPE)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_multicycle(id_multicycle), .flush(flush),
        .cmp_valid(cmp_valid), .cmp_rd(cmp_rd),
        .no_dependency(no_dependency), .no_collision(no_collision),
        .rd_not_busy(rd_not_busy), .busy_vec(busy_vec),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hazard rules evaluated directly over the model's busy array.
    function automatic bit freed_now(input logic [4:0] r);
        return cmp_valid && (cmp_rd == r);
    endfunction

    function automatic bit exp_no_dep();
        logic [4:0] src [3];
        bit hz = 0;
        src[0] = id_rs1; src[1] = id_rs2; src[2] = id_rs3;
        for (int k = 0; k < 3; k++)
            if (id_rs_used[k] && m_busy[src[k]] && !freed_now(src[k])) hz = 1;
        return !(id_valid && hz);
    endfunction

    function automatic bit exp_no_col();
        bit waw_h = id_valid && id_wen && m_busy[id_rd] && !freed_now(id_rd);
        bit str_h = id_valid && id_multicycle && (m_cnt == MAXP) && !cmp_valid;
        return !(waw_h || str_h);
    endfunction

    function automatic logic [31:0] exp_busy_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic bit model_accept();
        return id_valid && exp_no_dep() && exp_no_col() && !flush;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) m_busy[r] <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (cmp_valid) m_busy[cmp_rd] <= 1'b0;
            if (model_accept() && id_wen && id_multicycle && !(FP_TYPE == 0 && id_rd == 0))
                m_busy[id_rd] <= 1'b1;
            m_cnt <= m_cnt + ((model_accept() && id_wen && id_multicycle) ? 1 : 0)
                           - ((cmp_valid && m_cnt > 0) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("no_dependency", 32'(no_dependency), 32'(exp_no_dep()));
            check("no_collision",  32'(no_collision),  32'(exp_no_col()));
            check("rd_not_busy",   32'(rd_not_busy),   32'(!m_busy[id_rd]));
            check("busy_vec",      busy_vec,           exp_busy_vec());
            check("pending_count", 32'(pending_count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input bit v, input int rs1, input int used, input int rd,
                         input bit wen, input bit mc, input bit fl, input bit cv, input int crd);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'd0; id_rs3 = 5'd0;
        id_rs_used = 3'(used); id_rd = 5'(rd); id_wen = wen; id_multicycle = mc;
        flush = fl; cmp_valid = cv; cmp_rd = 5'(crd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        chk_en = 1'b1;
        settle();
        check("rst_no_dep",  32'(no_dependency), 32'd1);
        check("rst_no_col",  32'(no_collision),  32'd1);
        check("rst_rd_free", 32'(rd_not_busy),   32'd1);
        check("rst_busy",    busy_vec,           32'd0);
        check("rst_count",   32'(pending_count), 32'd0);

        // Multicycle write to x5, then a dependent read until writeback.
        cyc(); drive(1, 0, 0, 5, 1, 1, 0, 0, 0);
        cyc(); drive(1, 5, 1, 0, 0, 0, 0, 0, 0); settle();
        check("raw_busy5",  32'(busy_vec[5]),    32'd1);
        check("raw_stall",  32'(no_dependency),  32'd0);
        cyc(); settle();
        check("raw_stall2", 32'(no_dependency),  32'd0);
        cyc(); drive(1, 5, 1, 0, 0, 0, 0, 1, 5); settle();
        check("raw_bypass", 32'(no_dependency),  32'd1);
        cyc(); idle(); settle();
        check("raw_clear5", 32'(busy_vec[5]),    32'd0);

        // WAW on busy x7, then the same with x7 completing.
        do_reset();
        drive(1, 0, 0, 7, 1, 1, 0, 0, 0);
        cyc(); drive(1, 0, 0, 7, 1, 0, 0, 0, 0); settle();
        check("waw_col",    32'(no_collision), 32'd0);
        check("waw_rdbusy", 32'(rd_not_busy),  32'd0);
        drive(1, 0, 0, 7, 1, 0, 0, 1, 7); settle();
        check("waw_bypass", 32'(no_collision), 32'd1);

        // Structural limit with four writes in flight.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, i, 1, 1, 0, 0, 0);
            cyc();
        end
        drive(1, 0, 0, 10, 1, 1, 0, 0, 0); settle();
        check("str_count4", 32'(pending_count), 32'd4);
        check("str_col",    32'(no_collision),  32'd0);
        drive(1, 0, 0, 10, 1, 1, 0, 1, 1); settle();
        check("str_bypass", 32'(no_collision),  32'd1);
        cyc(); idle(); settle();
        check("str_keep4",  32'(pending_count), 32'd4);
        check("str_busy10", 32'(busy_vec[10]),  32'd1);
        check("str_free1",  32'(busy_vec[1]),   32'd0);

        // Same-edge set and clear on x9.
        do_reset();
        drive(1, 0, 0, 9, 1, 1, 0, 0, 0);
        cyc(); drive(1, 0, 0, 9, 1, 1, 0, 1, 9);
        cyc(); idle(); settle();
        check("sc_busy9", 32'(busy_vec[9]),    32'd1);
        check("sc_count", 32'(pending_count),  32'd1);

        // x0 is hard-wired in the integer file.
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(); drive(1, 0, 1, 0, 0, 0, 0, 0, 0); settle();
        check("x0_busy",   32'(busy_vec[0]),   32'd0);
        check("x0_no_dep", 32'(no_dependency), 32'd1);

        // Flush keeps in-flight state; reset discards it.
        do_reset();
        drive(1, 0, 0, 3, 1, 1, 0, 0, 0);
        cyc(); drive(1, 0, 0, 12, 1, 1, 1, 0, 0);
        cyc(); idle(); settle();
        check("fl_busy3",  32'(busy_vec[3]),   32'd1);
        check("fl_busy12", 32'(busy_vec[12]),  32'd0);
        check("fl_count",  32'(pending_count), 32'd1);
        do_reset(); settle();
        check("fr_busy",   busy_vec,           32'd0);
        check("fr_count",  32'(pending_count), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(); idle(); settle();
        check("fr_stale",  32'(pending_count), 32'd0);

        // Randomized traffic over a small register window to force hazards.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int busy_list [$];
            reset         = ($urandom_range(0, 299) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_rs3        = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            id_rs_used    = 3'($urandom);
            id_rd         = 5'($urandom_range(0, 9));
            id_wen        = ($urandom_range(0, 3) != 0);
            id_multicycle = $urandom_range(0, 1) == 1;
            flush         = ($urandom_range(0, 7) == 0);
            for (int r = 0; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
            cmp_valid = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                cmp_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                cmp_rd = 5'($urandom_range(0, 9));
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
